// File: rtl/calc1_pkg.sv
// Shared widths, command/response encodings and the per-port state type
// for the four-port round-robin calculator scheduler.
package calc1_pkg;

    localparam int DATA_W     = 32;
    localparam int CMD_W      = 4;
    localparam int RESP_W     = 2;
    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = $clog2(NUM_PORTS);

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    // state    | meaning
    // ST_IDLE  | waiting for a non-zero command (op1 arrives with it)
    // ST_OP2   | capturing op2 from the data bus, command bus ignored
    // ST_READY | operands complete, waiting for an ALU grant
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OP2   = 2'd1,
        ST_READY = 2'd2
    } port_state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational ALU shared by all ports. Any failure (carry out, borrow,
// unknown command) returns RESP_ERR with zero data.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [RESP_W-1:0] resp,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, op1} + {1'b0, op2};

    // Decode the command and produce the response code and result.
    always_comb begin
        resp = RESP_ERR;
        data = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp = RESP_OK;
                    data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            // Shift amount is the five least-significant bits of op2.
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> op2[4:0];
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_rr_sched.sv
// Four-port calculator front end: each port collects cmd/op1/op2 over two
// cycles, then competes round-robin for the single shared ALU. The result
// is registered and shown to the winning port for exactly one cycle.
module calc1_rr_sched
    import calc1_pkg::*;
(
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req1_cmd_in,
    input  logic [CMD_W-1:0]  req2_cmd_in,
    input  logic [CMD_W-1:0]  req3_cmd_in,
    input  logic [CMD_W-1:0]  req4_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [RESP_W-1:0] out1_resp,
    output logic [RESP_W-1:0] out2_resp,
    output logic [RESP_W-1:0] out3_resp,
    output logic [RESP_W-1:0] out4_resp,
    output logic [DATA_W-1:0] out1_data,
    output logic [DATA_W-1:0] out2_data,
    output logic [DATA_W-1:0] out3_data,
    output logic [DATA_W-1:0] out4_data
);

    logic [CMD_W-1:0]      cmd_in  [NUM_PORTS];
    logic [DATA_W-1:0]     data_in [NUM_PORTS];

    port_state_t           state_q [NUM_PORTS];
    port_state_t           state_d [NUM_PORTS];
    logic [CMD_W-1:0]      cmd_q   [NUM_PORTS];
    logic [DATA_W-1:0]     op1_q   [NUM_PORTS];
    logic [DATA_W-1:0]     op2_q   [NUM_PORTS];

    logic [PORT_IDX_W-1:0] last_q;
    logic [PORT_IDX_W-1:0] gnt_idx;
    logic                  gnt_vld;

    logic [CMD_W-1:0]      alu_cmd;
    logic [DATA_W-1:0]     alu_op1;
    logic [DATA_W-1:0]     alu_op2;
    logic [RESP_W-1:0]     alu_resp;
    logic [DATA_W-1:0]     alu_data;

    logic [RESP_W-1:0]     resp_q  [NUM_PORTS];
    logic [DATA_W-1:0]     rdata_q [NUM_PORTS];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    // Round-robin search starting at the port after the last one granted.
    always_comb begin
        logic [PORT_IDX_W-1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = last_q + PORT_IDX_W'(i);
            if (!gnt_vld && state_q[cand] == ST_READY) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Per-port next-state logic.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                ST_IDLE:  if (cmd_in[p] != CMD_NOP) state_d[p] = ST_OP2;
                ST_OP2:   state_d[p] = ST_READY;
                ST_READY: if (gnt_vld && gnt_idx == PORT_IDX_W'(p)) state_d[p] = ST_IDLE;
                default:  state_d[p] = ST_IDLE;
            endcase
        end
    end

    // Per-port state registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ST_IDLE;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
        end
    end

    // Operand capture: cmd/op1 on acceptance, op2 on the following cycle.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cmd_q[p] <= CMD_NOP;
                op1_q[p] <= '0;
                op2_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state_q[p] == ST_IDLE && cmd_in[p] != CMD_NOP) begin
                    cmd_q[p] <= cmd_in[p];
                    op1_q[p] <= data_in[p];
                end
                if (state_q[p] == ST_OP2) op2_q[p] <= data_in[p];
            end
        end
    end

    assign alu_cmd = cmd_q[gnt_idx];
    assign alu_op1 = op1_q[gnt_idx];
    assign alu_op2 = op2_q[gnt_idx];

    calc1_alu u_alu (
        .cmd  (alu_cmd),
        .op1  (alu_op1),
        .op2  (alu_op2),
        .resp (alu_resp),
        .data (alu_data)
    );

    // Register the ALU result for the granted port; all others read zero.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_IDX_W'(NUM_PORTS - 1);
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p]  <= RESP_NONE;
                rdata_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p]  <= RESP_NONE;
                rdata_q[p] <= '0;
            end
            if (gnt_vld) begin
                last_q           <= gnt_idx;
                resp_q[gnt_idx]  <= alu_resp;
                rdata_q[gnt_idx] <= alu_data;
            end
        end
    end

    assign out1_resp = resp_q[0];
    assign out2_resp = resp_q[1];
    assign out3_resp = resp_q[2];
    assign out4_resp = resp_q[3];
    assign out1_data = rdata_q[0];
    assign out2_data = rdata_q[1];
    assign out3_data = rdata_q[2];
    assign out4_data = rdata_q[3];

endmodule

// File: tb/tb_calc1_rr_sched.sv
// Directed bench for calc1_rr_sched: inputs change 1 ns after a rising
// edge, outputs are checked at that same point.
module tb_calc1_rr_sched;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd_a  [4];
    logic [31:0] din_a  [4];
    logic [1:0]  resp_w [4];
    logic [31:0] dout_w [4];

    int checks   = 0;
    int failures = 0;

    always #5 c_clk = ~c_clk;

    calc1_rr_sched dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_a[0]),
        .req2_cmd_in  (cmd_a[1]),
        .req3_cmd_in  (cmd_a[2]),
        .req4_cmd_in  (cmd_a[3]),
        .req1_data_in (din_a[0]),
        .req2_data_in (din_a[1]),
        .req3_data_in (din_a[2]),
        .req4_data_in (din_a[3]),
        .out1_resp    (resp_w[0]),
        .out2_resp    (resp_w[1]),
        .out3_resp    (resp_w[2]),
        .out4_resp    (resp_w[3]),
        .out1_data    (dout_w[0]),
        .out2_data    (dout_w[1]),
        .out3_data    (dout_w[2]),
        .out4_data    (dout_w[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input int p, input logic [1:0] er, input logic [31:0] ed);
        chk($sformatf("%s_p%0d_resp", tag, p + 1), {30'd0, resp_w[p]}, {30'd0, er});
        chk($sformatf("%s_p%0d_data", tag, p + 1), dout_w[p], ed);
    endtask

    task automatic chk_all_idle(input string tag);
        for (int q = 0; q < 4; q++) chk_port(tag, q, 2'd0, 32'd0);
    endtask

    task automatic chk_only(input string tag, input int p, input logic [1:0] er, input logic [31:0] ed);
        for (int q = 0; q < 4; q++) begin
            if (q == p) chk_port(tag, q, er, ed);
            else        chk_port(tag, q, 2'd0, 32'd0);
        end
    endtask

    // One isolated transaction: cmd+op1 at T, op2 at T+1, response at T+3 only.
    task automatic single(input string tag, input int p, input logic [3:0] cmd,
                          input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] er, input logic [31:0] ed);
        cmd_a[p] = cmd;
        din_a[p] = op1;
        tick();
        cmd_a[p] = 4'd0;
        din_a[p] = op2;
        tick();
        din_a[p] = 32'd0;
        chk_all_idle({tag, "_early"});
        tick();
        chk_only(tag, p, er, ed);
        tick();
        chk_all_idle({tag, "_after"});
    endtask

    initial begin
        for (int q = 0; q < 4; q++) begin
            cmd_a[q] = 4'd0;
            din_a[q] = 32'd0;
        end

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk_all_idle("reset");

        // First command on the first edge after release
        reset = 1'b0;
        single("add_basic", 0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);

        single("add_carry", 0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0);
        single("add_max",   0, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF);
        single("sub_under", 1, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0);
        single("sub_equal", 1, 4'd2, 32'h0000_000F, 32'h0000_000F, 2'd1, 32'd0);
        single("inv_cmd3",  2, 4'd3, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'd0);
        single("inv_cmd15", 2, 4'd15, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'd0);
        single("shl_4",     3, 4'd5, 32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010);
        single("shl_mask",  3, 4'd5, 32'h0000_0003, 32'hFFFF_FFE4, 2'd1, 32'h0000_0030);
        single("shr_31",    3, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001);

        // All four ports add k+k together; pointer sits at port 4
        for (int q = 0; q < 4; q++) begin
            cmd_a[q] = 4'd1;
            din_a[q] = 32'(q + 1);
        end
        tick();
        for (int q = 0; q < 4; q++) cmd_a[q] = 4'd0;
        tick();
        for (int q = 0; q < 4; q++) din_a[q] = 32'd0;
        chk_all_idle("rr1_early");
        tick();
        chk_only("rr1_t3", 0, 2'd1, 32'd2);
        tick();
        chk_only("rr1_t4", 1, 2'd1, 32'd4);
        tick();
        chk_only("rr1_t5", 2, 2'd1, 32'd6);
        tick();
        chk_only("rr1_t6", 3, 2'd1, 32'd8);

        // Immediate second round: (k+10)+(k+10)
        for (int q = 0; q < 4; q++) begin
            cmd_a[q] = 4'd1;
            din_a[q] = 32'(q + 11);
        end
        tick();
        for (int q = 0; q < 4; q++) cmd_a[q] = 4'd0;
        chk_all_idle("rr2_t1");
        tick();
        for (int q = 0; q < 4; q++) din_a[q] = 32'd0;
        chk_all_idle("rr2_t2");
        tick();
        chk_only("rr2_t3", 0, 2'd1, 32'd22);
        tick();
        chk_only("rr2_t4", 1, 2'd1, 32'd24);
        tick();
        chk_only("rr2_t5", 2, 2'd1, 32'd26);
        tick();
        chk_only("rr2_t6", 3, 2'd1, 32'd28);
        tick();
        chk_all_idle("rr2_done");

        // Rotation: last grant to port 2, then ports 1 and 3 contend -> port 3 first
        single("sub_basic", 1, 4'd2, 32'h0000_000A, 32'h0000_0003, 2'd1, 32'd7);
        cmd_a[0] = 4'd1; din_a[0] = 32'd1;
        cmd_a[2] = 4'd1; din_a[2] = 32'd2;
        tick();
        cmd_a[0] = 4'd0;
        cmd_a[2] = 4'd0;
        tick();
        din_a[0] = 32'd0;
        din_a[2] = 32'd0;
        tick();
        chk_only("rot_first", 2, 2'd1, 32'd4);
        tick();
        chk_only("rot_second", 0, 2'd1, 32'd2);

        // New command accepted in the same cycle the previous response shows
        cmd_a[0] = 4'd1; din_a[0] = 32'd2;
        tick();
        cmd_a[0] = 4'd0; din_a[0] = 32'd2;
        tick();
        din_a[0] = 32'd0;
        tick();
        chk_only("b2b_first", 0, 2'd1, 32'd4);
        cmd_a[0] = 4'd1; din_a[0] = 32'd3;
        tick();
        cmd_a[0] = 4'd0;
        chk_all_idle("b2b_gap1");
        tick();
        din_a[0] = 32'd0;
        chk_all_idle("b2b_gap2");
        tick();
        chk_only("b2b_second", 0, 2'd1, 32'd6);

        // Commands during OP2 and READY are ignored
        cmd_a[0] = 4'd1; din_a[0] = 32'd5;
        tick();
        cmd_a[0] = 4'd2; din_a[0] = 32'd6;
        tick();
        cmd_a[0] = 4'd1; din_a[0] = 32'd100;
        tick();
        cmd_a[0] = 4'd0; din_a[0] = 32'd0;
        chk_only("ign_resp", 0, 2'd1, 32'd11);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all_idle($sformatf("ign_quiet%0d", k));
        end

        // Reset while port 1 is READY discards the request
        cmd_a[0] = 4'd1; din_a[0] = 32'd7;
        tick();
        cmd_a[0] = 4'd0; din_a[0] = 32'd8;
        tick();
        din_a[0] = 32'd0;
        reset = 1'b1;
        #1;
        chk_all_idle("rst_mid_a");
        tick();
        chk_all_idle("rst_mid_b");
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all_idle($sformatf("rst_quiet%0d", k));
        end
        single("post_rst_add", 0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
